// File: rtl/bip_control_if.sv
// Datapath-facing bundle of the BIP control unit: program-memory fetch port plus
// the decoded strobes for the accumulator/ALU/data-RAM stage.
interface bip_control_if #(
  parameter int NBITS_I   = 16,
  parameter int NBITS_OP  = 11,
  parameter int NBITS_PC  = 11,
  parameter int NBITS_CNT = 16
);
  // No valid/ready: o_PC is presented in FETCH, i_Instr must hold the word at that
  // address one cycle later (EXEC), and every strobe is a single-cycle EXEC pulse.
  logic                 i_Enable;
  logic [NBITS_I-1:0]   i_Instr;
  logic [NBITS_PC-1:0]  o_PC;
  logic [1:0]           o_SelA;
  logic                 o_SelB;
  logic                 o_Op;
  logic                 o_WrAcc;
  logic                 o_WrRam;
  logic                 o_RdRam;
  logic [NBITS_OP-1:0]  o_Operand;
  logic                 o_Halted;
  logic [NBITS_CNT-1:0] o_InstrCount;
  logic [1:0]           o_State;

  modport slave (
    input  i_Enable, i_Instr,
    output o_PC, o_SelA, o_SelB, o_Op, o_WrAcc, o_WrRam, o_RdRam,
           o_Operand, o_Halted, o_InstrCount, o_State
  );

  modport master (
    output i_Enable, i_Instr,
    input  o_PC, o_SelA, o_SelB, o_Op, o_WrAcc, o_WrRam, o_RdRam,
           o_Operand, o_Halted, o_InstrCount, o_State
  );
endinterface

// File: rtl/bip_control.sv
// BIP instruction sequencer: PC, two-phase FETCH/EXEC decode, terminal HALT and a
// saturating retired-instruction counter. o_State exposes the FSM for debug.
module bip_control #(
  parameter int NBITS_I   = 16,
  parameter int NBITS_OP  = 11,
  parameter int NBITS_PC  = 11,
  parameter int NBITS_CNT = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  bip_control_if.slave  bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  state_t               state_q, state_d;
  logic [NBITS_PC-1:0]  pc_q, pc_d;
  logic [NBITS_CNT-1:0] cnt_q, cnt_d;

  logic [4:0]           opcode;
  logic [1:0]           sel_a;
  logic                 sel_b, op, wr_acc, wr_ram, rd_ram, halted;
  logic [NBITS_OP-1:0]  operand;

  assign opcode = bus.i_Instr[NBITS_I-1 -: 5];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode from state_q only, so an async reset drops every strobe at once.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    sel_a   = 2'b00;
    sel_b   = 1'b0;
    op      = 1'b0;
    wr_acc  = 1'b0;
    wr_ram  = 1'b0;
    rd_ram  = 1'b0;
    halted  = 1'b0;
    operand = '0;
    case (state_q)
      S_FETCH: begin
        if (bus.i_Enable) state_d = S_EXEC;
      end
      S_EXEC: begin
        operand = bus.i_Instr[NBITS_OP-1:0];
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + NBITS_CNT'(1);
        if (opcode == OP_HLT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          pc_d    = pc_q + NBITS_PC'(1);
        end
        case (opcode)
          OP_STO:  wr_ram = 1'b1;
          OP_LD:   begin rd_ram = 1'b1; wr_acc = 1'b1; end
          OP_LDI:  begin sel_a = 2'b01; wr_acc = 1'b1; end
          OP_ADD:  begin rd_ram = 1'b1; sel_a = 2'b10; wr_acc = 1'b1; end
          OP_ADDI: begin sel_a = 2'b10; sel_b = 1'b1; wr_acc = 1'b1; end
          OP_SUB:  begin rd_ram = 1'b1; sel_a = 2'b10; op = 1'b1; wr_acc = 1'b1; end
          OP_SUBI: begin sel_a = 2'b10; sel_b = 1'b1; op = 1'b1; wr_acc = 1'b1; end
          default: ;
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.o_PC         = pc_q;
  assign bus.o_SelA       = sel_a;
  assign bus.o_SelB       = sel_b;
  assign bus.o_Op         = op;
  assign bus.o_WrAcc      = wr_acc;
  assign bus.o_WrRam      = wr_ram;
  assign bus.o_RdRam      = rd_ram;
  assign bus.o_Operand    = operand;
  assign bus.o_Halted     = halted;
  assign bus.o_InstrCount = cnt_q;
  assign bus.o_State      = state_q;

endmodule
